dmmu: RTL
=========

DMMU -- requirements
Module: dmmu

Interface
REQ-001 Parameter TLB_ENTRIES, default 4, number of fully-associative TLB entries (power of two, 2..16).
REQ-002 clk  in  1  clock; rstn  in  1  reset, synchronous, active-low.
REQ-003 req_enable  in  1  one-cycle request pulse from mem stage; req_mode  in  1  MEMREQ_READ/MEMREQ_WRITE.
REQ-004 req_addr  in  32  virtual word address; req_wdata  in  32  store data; req_wstrb  in  4  byte strobes; flush_tlb  in  1  sampled with req_enable.
REQ-005 resp_enable  out  1  one-cycle completion pulse; resp_data  out  32  read data; page_fault  out  1  valid with resp_enable; fault_cause  out  4  13 load / 15 store; fault_tval  out  32  faulting VA.
REQ-006 satp  in  32  CSR; priv  in  2  current privilege; sum  in  1  mstatus.SUM; mxr  in  1  mstatus.MXR.
REQ-007 bus_req_enable  out  1  one-cycle pulse; bus_mode  out  1; bus_addr  out  32  physical; bus_wdata  out  32; bus_wstrb  out  4; bus_resp_enable  in  1; bus_data  in  32.

Function
REQ-008 States: IDLE, WALK1, WALK2, ACCESS, FLUSH_DONE; req_enable outside IDLE is ignored.
REQ-009 Translation off when satp[31]=0 or priv=M: PA=VA, request forwarded to bus in cycle N+1 after acceptance in N, state ACCESS.
REQ-010 TLB hit (valid, tag=VA[31:22] for megapage else VA[31:12], permissions pass): bus_req_enable in N+1, PA={ppn,VA[11:0]} or {ppn[19:10],VA[21:0]}.
REQ-011 Miss: WALK1 issues READ at {satp[19:0],12'b0}+VA[31:22]*4 in N+1.
REQ-012 PTE = byte-swapped bus_data (to_le32), matching mem-stage byte order.
REQ-013 PTE V=0, or R=0&W=1 -> fault; R|X=1 at level 1 with ppn[9:0]!=0 -> fault; R|X=1 -> leaf; else pointer.
REQ-014 Pointer at level 1: WALK2 reads {pte.ppn[19:0],12'b0}+VA[21:12]*4; non-leaf at level 2 -> fault.
REQ-015 Permission: load needs R or (X and mxr); store needs W; priv U needs U=1; priv S with U=1 needs sum=1.
REQ-016 A=0, or store with D=0 -> fault; block never writes PTEs.
REQ-017 Valid leaf fills TLB entry at round-robin pointer (pointer increments per fill, wraps at TLB_ENTRIES-1), then ACCESS issues the original request.
REQ-018 Physical addresses truncated to 32 bits (ppn[19:0]).
REQ-019 Fault: resp_enable=1, page_fault=1, fault_cause per req_mode, fault_tval=req_addr, resp_data=0, one cycle after detection; no bus access.
REQ-020 ACCESS: on bus_resp_enable, resp_enable=1 next cycle, resp_data=bus_data unmodified, page_fault=0, return IDLE.
REQ-021 req_enable with flush_tlb=1: invalidate all entries, no bus access, resp_enable in N+1 with resp_data=0, page_fault=0.
REQ-022 Request fields latched at acceptance; changes on inputs during a walk are ignored.
REQ-023 bus_req_enable, resp_enable strictly single-cycle pulses; at most one outstanding bus request.

Reset
REQ-024 rstn=0 at any state: state IDLE, all TLB valid bits 0, RR pointer 0, all outputs 0, in-flight bus response discarded.

Structure
REQ-025 MEMREQ_READ/WRITE, to_le32, PTE bit-index constants and cause codes live in def.sv package.
REQ-026 One sub-module dmmu_tlb (lookup, fill, flush, RR pointer); walker FSM in dmmu.

Verification
REQ-027 satp=0, READ 0x8000_0010 -> bus_addr 0x8000_0010, resp_data=bus_data, latency 1 cycle to bus.
REQ-028 satp=0x8000_0100, VA 0x0040_1000, L1 PTE(0x0010_0004)=0x0000_0401 pointer, L2 PTE=0x2000_00CF -> bus_addr 0x8000_0000; repeat hits TLB, no walk.
REQ-029 Store to page with D=0 -> page_fault=1, cause 15, tval=VA, no bus write.
REQ-030 priv S, sum=0, leaf U=1 load -> cause 13; same with sum=1 -> succeeds.
REQ-031 Fill 5 pages with TLB_ENTRIES=4 -> first evicted; flush_tlb request -> resp next cycle, next access walks.
REQ-032 rstn low during WALK2 -> IDLE, outputs 0, late bus_resp_enable ignored.

Source files
------------

// File: rtl/dmmu_pkg.sv
// dmmu_pkg: shared request encodings, Sv32 PTE bit indices, fault causes and helpers for the DMMU.
package dmmu_pkg;
  localparam logic MEMREQ_READ = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;
  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;
  localparam logic [3:0] CAUSE_LOAD_PF = 4'd13;
  localparam logic [3:0] CAUSE_STORE_PF = 4'd15;
  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_M = 2'd3;
  typedef enum logic [2:0] {IDLE, WALK1, WALK2, ACCESS, FLUSH_DONE} state_t;
  function automatic logic [31:0] to_le32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
  // Leaf permission check; the A/D bits are folded in because this block never updates PTEs.
  function automatic logic pte_ok(input logic [7:0] f, input logic mode, input logic [1:0] priv,
                                  input logic sum, input logic mxr);
    return (mode == MEMREQ_WRITE ? f[PTE_W] & f[PTE_D] : f[PTE_R] | (f[PTE_X] & mxr)) & f[PTE_A] &
           (priv == PRIV_U ? f[PTE_U] : !f[PTE_U] | sum);
  endfunction
endpackage

// File: rtl/dmmu_tlb.sv
// dmmu_tlb: fully-associative TLB with round-robin replacement, megapage support and bulk flush.
module dmmu_tlb
  import dmmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_flush,
  input  logic [31:0] i_va,
  input  logic        i_mode,
  input  logic [1:0]  i_priv,
  input  logic        i_sum,
  input  logic        i_mxr,
  output logic        o_hit,
  output logic [31:0] o_pa,
  input  logic        i_fill,
  input  logic [19:0] i_fill_tag,
  input  logic        i_fill_mega,
  input  logic [19:0] i_fill_ppn,
  input  logic [7:0]  i_fill_flags
);
  localparam int PW = $clog2(TLB_ENTRIES);
  logic [TLB_ENTRIES-1:0] r_valid, r_mega;
  logic [19:0] r_tag [TLB_ENTRIES];
  logic [19:0] r_ppn [TLB_ENTRIES];
  logic [7:0] r_flags [TLB_ENTRIES];
  logic [PW-1:0] r_ptr;
  // Entries failing the permission check count as misses so the walker reports the fault.
  always_comb begin
    o_hit = 1'b0;
    o_pa = 32'd0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--)
      if (r_valid[i] && (r_mega[i] ? r_tag[i][19:10] == i_va[31:22] : r_tag[i] == i_va[31:12]) &&
          pte_ok(r_flags[i], i_mode, i_priv, i_sum, i_mxr)) begin
        o_hit = 1'b1;
        o_pa = r_mega[i] ? {r_ppn[i][19:10], i_va[21:0]} : {r_ppn[i], i_va[11:0]};
      end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= '0;
      r_ptr <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_fill) begin
      r_valid[r_ptr] <= 1'b1;
      r_mega[r_ptr] <= i_fill_mega;
      r_tag[r_ptr] <= i_fill_tag;
      r_ppn[r_ptr] <= i_fill_ppn;
      r_flags[r_ptr] <= i_fill_flags;
      r_ptr <= r_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/dmmu.sv
// dmmu: Sv32 data MMU with a two-level page walker in front of a single-outstanding memory bus.
module dmmu
  import dmmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req_enable,
  input  logic        i_req_mode,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  input  logic        i_flush_tlb,
  output logic        o_resp_enable,
  output logic [31:0] o_resp_data,
  output logic        o_page_fault,
  output logic [3:0]  o_fault_cause,
  output logic [31:0] o_fault_tval,
  input  logic [31:0] i_satp,
  input  logic [1:0]  i_priv,
  input  logic        i_sum,
  input  logic        i_mxr,
  output logic        o_bus_req_enable,
  output logic        o_bus_mode,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic        i_bus_resp_enable,
  input  logic [31:0] i_bus_data
);
  state_t r_state;
  logic [31:0] r_va, r_wdata, r_resp_data, r_tval, r_bus_addr, r_bus_wdata;
  logic [3:0] r_wstrb, r_cause, r_bus_wstrb;
  logic [1:0] r_priv;
  logic r_mode, r_sum, r_mxr, r_resp, r_pf, r_bus_req, r_bus_mode;
  logic w_xlate, w_accept, w_walk, w_lvl1, w_leaf, w_bad, w_fill, w_hit, w_unused;
  logic [31:0] w_pte, w_pa, w_hit_pa;
  assign w_xlate = i_satp[31] && i_priv != PRIV_M;
  assign w_accept = r_state == IDLE && i_req_enable;
  assign w_walk = r_state == WALK1 || r_state == WALK2;
  assign w_lvl1 = r_state == WALK1;
  assign w_pte = to_le32(i_bus_data);
  assign w_leaf = w_pte[PTE_R] | w_pte[PTE_X];
  // Level-1 leaves must be 4 MiB aligned; a pointer at level 2 is malformed.
  assign w_bad = !w_pte[PTE_V] || (!w_pte[PTE_R] && w_pte[PTE_W]) ||
                 (w_leaf ? (w_lvl1 && w_pte[19:10] != 10'd0) ||
                           !pte_ok(w_pte[7:0], r_mode, r_priv, r_sum, r_mxr) : !w_lvl1);
  assign w_fill = w_walk && i_bus_resp_enable && w_leaf && !w_bad;
  assign w_pa = w_lvl1 ? {w_pte[29:20], r_va[21:0]} : {w_pte[29:10], r_va[11:0]};
  assign w_unused = ^{i_satp[30:20], w_pte[31:30], w_pte[9:8]};
  dmmu_tlb #(.TLB_ENTRIES(TLB_ENTRIES)) u_tlb (
    .clk(clk), .rstn(rstn), .i_flush(w_accept && i_flush_tlb),
    .i_va(i_req_addr), .i_mode(i_req_mode), .i_priv(i_priv), .i_sum(i_sum), .i_mxr(i_mxr),
    .o_hit(w_hit), .o_pa(w_hit_pa),
    .i_fill(w_fill), .i_fill_tag(r_va[31:12]), .i_fill_mega(w_lvl1),
    .i_fill_ppn(w_pte[29:10]), .i_fill_flags(w_pte[7:0])
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      {r_va, r_wdata, r_wstrb, r_priv, r_mode, r_sum, r_mxr} <= '0;
      {r_resp, r_resp_data, r_pf, r_cause, r_tval} <= '0;
      {r_bus_req, r_bus_mode, r_bus_addr, r_bus_wdata, r_bus_wstrb} <= '0;
    end else begin
      r_bus_req <= 1'b0;
      {r_resp, r_resp_data, r_pf, r_cause, r_tval} <= '0;
      case (r_state)
        IDLE: if (i_req_enable) begin
          {r_va, r_wdata, r_wstrb, r_mode} <= {i_req_addr, i_req_wdata, i_req_wstrb, i_req_mode};
          {r_priv, r_sum, r_mxr} <= {i_priv, i_sum, i_mxr};
          if (i_flush_tlb) begin
            r_resp <= 1'b1;
            r_state <= FLUSH_DONE;
          end else if (!w_xlate || w_hit) begin
            r_bus_req <= 1'b1;
            r_bus_mode <= i_req_mode;
            r_bus_addr <= w_xlate ? w_hit_pa : i_req_addr;
            r_bus_wdata <= i_req_wdata;
            r_bus_wstrb <= i_req_wstrb;
            r_state <= ACCESS;
          end else begin
            r_bus_req <= 1'b1;
            r_bus_mode <= MEMREQ_READ;
            r_bus_addr <= {i_satp[19:0], i_req_addr[31:22], 2'b00};
            r_bus_wdata <= 32'd0;
            r_bus_wstrb <= 4'd0;
            r_state <= WALK1;
          end
        end
        WALK1, WALK2: if (i_bus_resp_enable) begin
          if (w_bad) begin
            r_resp <= 1'b1;
            r_pf <= 1'b1;
            r_cause <= r_mode == MEMREQ_WRITE ? CAUSE_STORE_PF : CAUSE_LOAD_PF;
            r_tval <= r_va;
            r_state <= IDLE;
          end else if (w_leaf) begin
            r_bus_req <= 1'b1;
            r_bus_mode <= r_mode;
            r_bus_addr <= w_pa;
            r_bus_wdata <= r_wdata;
            r_bus_wstrb <= r_wstrb;
            r_state <= ACCESS;
          end else begin
            r_bus_req <= 1'b1;
            r_bus_addr <= {w_pte[29:10], r_va[21:12], 2'b00};
            r_state <= WALK2;
          end
        end
        ACCESS: if (i_bus_resp_enable) begin
          r_resp <= 1'b1;
          r_resp_data <= i_bus_data;
          r_state <= IDLE;
        end
        FLUSH_DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_resp_enable = r_resp;
  assign o_resp_data = r_resp_data;
  assign o_page_fault = r_pf;
  assign o_fault_cause = r_cause;
  assign o_fault_tval = r_tval;
  assign o_bus_req_enable = r_bus_req;
  assign o_bus_mode = r_bus_mode;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_wstrb = r_bus_wstrb;
endmodule
